// File: rtl/cart_rom_server.sv
// cart_rom_server
// Memory-side responder for the console cartridge/BIOS fetch interface.
// Each source (cart, BIOS) owns a one-word buffer that is filled from external
// SDRAM-style storage over a req/ack handshake. The same handshake carries the
// ROM loader's byte writes during download.
//
// Optional build feature (macro CART_PREFETCH_EN): after every cart fill the
// following cart word is fetched into a second "next-line" cart buffer.
module cart_rom_server #(
    parameter logic [23:0] CART_BASE = 24'h000000,
    parameter logic [23:0] BIOS_BASE = 24'h040000
) (
    input  logic        sysclk_7_143,
    input  logic        reset,
    input  logic        cart_sel,
    input  logic [17:0] cart_addr,
    output logic [7:0]  cart_out,
    input  logic        bios_sel,
    input  logic [11:0] bios_addr,
    output logic [7:0]  bios_out,
    input  logic        loading,
    input  logic        dl_wr,
    input  logic [18:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_CART = 3'd1;
    localparam logic [2:0] ST_RD_BIOS = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
`ifdef CART_PREFETCH_EN
    localparam logic [2:0] ST_PREF    = 3'd4;
`endif

    logic [2:0]  state_reg;
    // Word address of the fetch in flight; the fill uses this, not the live
    // address, so a select/address change mid-fetch cannot corrupt the tag.
    logic [16:0] req_tag_reg;

    // Cart word buffer
    logic        cart_valid_reg;
    logic [16:0] cart_tag_reg;
    logic [15:0] cart_data_reg;

    // BIOS word buffer
    logic        bios_valid_reg;
    logic [10:0] bios_tag_reg;
    logic [15:0] bios_data_reg;

`ifdef CART_PREFETCH_EN
    // Next-line cart buffer and the prefetch that feeds it
    logic        next_valid_reg;
    logic [16:0] next_tag_reg;
    logic [15:0] next_data_reg;
    logic        pref_pending_reg;
    logic [16:0] pref_word_reg;
    logic        cart_hit_next;
    logic [23:0] pref_addr;
`endif

    // Pending download write
    logic        dl_wait_reg;
    logic [18:0] pend_addr_reg;
    logic [7:0]  pend_data_reg;

    // Output hold registers and loading edge detect
    logic [7:0]  cart_last_reg;
    logic [7:0]  bios_last_reg;
    logic        loading_prev_reg;

    // ------------------------------------------------------------------
    // Hit detection and read data
    // ------------------------------------------------------------------
    logic [16:0] cart_word;
    logic [10:0] bios_word;
    logic        cart_hit_main;
    logic        cart_hit;
    logic [15:0] cart_hit_data;
    logic        bios_hit;
    logic        cart_miss;
    logic        bios_miss;
    logic        flush;

    assign cart_word     = cart_addr[17:1];
    assign bios_word     = bios_addr[11:1];
    assign cart_hit_main = cart_valid_reg && (cart_tag_reg == cart_word);
    assign bios_hit      = bios_valid_reg && (bios_tag_reg == bios_word);

`ifdef CART_PREFETCH_EN
    assign cart_hit_next = next_valid_reg && (next_tag_reg == cart_word);
    assign cart_hit      = cart_hit_main || cart_hit_next;
    assign cart_hit_data = cart_hit_main ? cart_data_reg : next_data_reg;
`else
    assign cart_hit      = cart_hit_main;
    assign cart_hit_data = cart_data_reg;
`endif

    // On a miss the output falls back to whatever it showed last cycle.
    assign cart_out = cart_hit ? (cart_addr[0] ? cart_hit_data[15:8] : cart_hit_data[7:0])
                               : cart_last_reg;
    assign bios_out = bios_hit ? (bios_addr[0] ? bios_data_reg[15:8] : bios_data_reg[7:0])
                               : bios_last_reg;

    // Reads are not issued while the image is being downloaded.
    assign cart_miss = cart_sel && !cart_hit && !loading;
    assign bios_miss = bios_sel && !bios_hit && !loading;

    // Download content may overwrite anything cached: drop all buffers while
    // loading and once more on the cycle loading falls.
    assign flush = loading || (loading_prev_reg && !loading);

    // ------------------------------------------------------------------
    // Address arithmetic (24-bit, wraps modulo 2^24)
    // ------------------------------------------------------------------
    logic [23:0] cart_rd_addr;
    logic [23:0] bios_rd_addr;
    logic [23:0] wr_addr;
    logic [1:0]  wr_be;
    logic        wr_hits_cart;
    logic        wr_hits_bios;

    assign cart_rd_addr = CART_BASE + {6'd0, cart_word, 1'b0};
    assign bios_rd_addr = BIOS_BASE + {12'd0, bios_word, 1'b0};
    assign wr_addr      = pend_addr_reg[18] ? (BIOS_BASE + {12'd0, pend_addr_reg[11:1], 1'b0})
                                            : (CART_BASE + {6'd0, pend_addr_reg[17:1], 1'b0});
    assign wr_be        = pend_addr_reg[0] ? 2'b10 : 2'b01;

    // A write to a word held in a buffer makes that buffer stale.
    assign wr_hits_cart = !pend_addr_reg[18] && (cart_tag_reg == pend_addr_reg[17:1]);
    assign wr_hits_bios =  pend_addr_reg[18] && (bios_tag_reg == pend_addr_reg[11:1]);

`ifdef CART_PREFETCH_EN
    logic wr_hits_next;
    assign wr_hits_next = !pend_addr_reg[18] && (next_tag_reg == pend_addr_reg[17:1]);
    assign pref_addr    = CART_BASE + {6'd0, pref_word_reg, 1'b0};
`endif

    assign dl_wait = dl_wait_reg;

    // ------------------------------------------------------------------
    // Request FSM: arbitrates in IDLE, holds the request until mem_ack
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk_7_143 or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            req_tag_reg      <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_be           <= 2'b00;
            mem_wdata        <= '0;
`ifdef CART_PREFETCH_EN
            pref_pending_reg <= 1'b0;
            pref_word_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (dl_wait_reg) begin
                        state_reg <= ST_WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_be    <= wr_be;
                        mem_wdata <= {pend_data_reg, pend_data_reg};
`ifdef CART_PREFETCH_EN
                        pref_pending_reg <= 1'b0;
`endif
                    end else if (cart_miss) begin
                        state_reg   <= ST_RD_CART;
                        req_tag_reg <= cart_word;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= cart_rd_addr;
                        mem_be      <= 2'b11;
                        mem_wdata   <= '0;
`ifdef CART_PREFETCH_EN
                        pref_pending_reg <= 1'b0;
`endif
                    end else if (bios_miss) begin
                        state_reg   <= ST_RD_BIOS;
                        req_tag_reg <= {6'd0, bios_word};
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= bios_rd_addr;
                        mem_be      <= 2'b11;
                        mem_wdata   <= '0;
`ifdef CART_PREFETCH_EN
                        pref_pending_reg <= 1'b0;
`endif
                    end
`ifdef CART_PREFETCH_EN
                    else if (pref_pending_reg && !loading) begin
                        state_reg        <= ST_PREF;
                        req_tag_reg      <= pref_word_reg;
                        mem_req          <= 1'b1;
                        mem_we           <= 1'b0;
                        mem_addr         <= pref_addr;
                        mem_be           <= 2'b11;
                        mem_wdata        <= '0;
                        pref_pending_reg <= 1'b0;
                    end else if (loading) begin
                        pref_pending_reg <= 1'b0;
                    end
`endif
                end
                default: begin
                    // Outputs stay frozen until the ack; mem_req then drops
                    // and IDLE guarantees a low cycle before the next request.
                    if (mem_ack) begin
                        state_reg <= ST_IDLE;
                        mem_req   <= 1'b0;
`ifdef CART_PREFETCH_EN
                        if (state_reg == ST_RD_CART) begin
                            pref_word_reg    <= req_tag_reg + 17'd1;
                            pref_pending_reg <= !dl_wait_reg && !bios_miss && !loading;
                        end
`endif
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Buffer fill on read acks, invalidation by writes and by loading
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk_7_143 or posedge reset) begin
        if (reset) begin
            cart_valid_reg <= 1'b0;
            cart_tag_reg   <= '0;
            cart_data_reg  <= '0;
            bios_valid_reg <= 1'b0;
            bios_tag_reg   <= '0;
            bios_data_reg  <= '0;
`ifdef CART_PREFETCH_EN
            next_valid_reg <= 1'b0;
            next_tag_reg   <= '0;
            next_data_reg  <= '0;
`endif
        end else begin
            if (mem_ack) begin
                case (state_reg)
                    ST_RD_CART: begin
                        cart_valid_reg <= 1'b1;
                        cart_tag_reg   <= req_tag_reg;
                        cart_data_reg  <= mem_rdata;
                    end
                    ST_RD_BIOS: begin
                        bios_valid_reg <= 1'b1;
                        bios_tag_reg   <= req_tag_reg[10:0];
                        bios_data_reg  <= mem_rdata;
                    end
`ifdef CART_PREFETCH_EN
                    ST_PREF: begin
                        next_valid_reg <= 1'b1;
                        next_tag_reg   <= req_tag_reg;
                        next_data_reg  <= mem_rdata;
                    end
`endif
                    ST_WRITE: begin
                        if (wr_hits_cart) cart_valid_reg <= 1'b0;
                        if (wr_hits_bios) bios_valid_reg <= 1'b0;
`ifdef CART_PREFETCH_EN
                        if (wr_hits_next) next_valid_reg <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
            // Placed last so a flush overrides a fill landing on the same edge.
            if (flush) begin
                cart_valid_reg <= 1'b0;
                bios_valid_reg <= 1'b0;
`ifdef CART_PREFETCH_EN
                next_valid_reg <= 1'b0;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Download write capture; one write outstanding at a time
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk_7_143 or posedge reset) begin
        if (reset) begin
            dl_wait_reg   <= 1'b0;
            pend_addr_reg <= '0;
            pend_data_reg <= '0;
        end else if (state_reg == ST_WRITE && mem_ack) begin
            dl_wait_reg <= 1'b0;
        end else if (dl_wr && !dl_wait_reg) begin
            dl_wait_reg   <= 1'b1;
            pend_addr_reg <= dl_addr;
            pend_data_reg <= dl_data;
        end
    end

    // ------------------------------------------------------------------
    // Hold the last presented bytes and remember the previous loading level
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk_7_143 or posedge reset) begin
        if (reset) begin
            cart_last_reg    <= 8'hFF;
            bios_last_reg    <= 8'hFF;
            loading_prev_reg <= 1'b0;
        end else begin
            cart_last_reg    <= cart_out;
            bios_last_reg    <= bios_out;
            loading_prev_reg <= loading;
        end
    end

endmodule

// File: tb/tb_cart_rom_server.sv
// Testbench for cart_rom_server: directed steps followed by randomized reads
// and download writes, compared against a word-level memory model.
module tb_cart_rom_server;

    localparam logic [23:0] CART_BASE = 24'h000000;
    localparam logic [23:0] BIOS_BASE = 24'h040000;

    logic        sysclk_7_143 = 1'b0;
    logic        reset = 1'b1;
    logic        cart_sel = 1'b0;
    logic [17:0] cart_addr = '0;
    logic [7:0]  cart_out;
    logic        bios_sel = 1'b0;
    logic [11:0] bios_addr = '0;
    logic [7:0]  bios_out;
    logic        loading = 1'b0;
    logic        dl_wr = 1'b0;
    logic [18:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_wait;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    always #5 sysclk_7_143 = ~sysclk_7_143;

    cart_rom_server #(.CART_BASE(CART_BASE), .BIOS_BASE(BIOS_BASE)) dut (
        .sysclk_7_143(sysclk_7_143), .reset(reset),
        .cart_sel(cart_sel), .cart_addr(cart_addr), .cart_out(cart_out),
        .bios_sel(bios_sel), .bios_addr(bios_addr), .bios_out(bios_out),
        .loading(loading), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_wait(dl_wait), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory models ----------------
    logic [15:0] ext_mem [int unsigned];   // what the responder serves (written by DUT requests)
    logic [15:0] ref_mem [int unsigned];   // what the bench expects (written from loader inputs)

    function automatic logic [15:0] init_word(input int unsigned w);
        return 16'((w * 32'd40503) ^ 32'h5AC3);
    endfunction
    function automatic logic [15:0] ext_rd(input int unsigned w);
        if (ext_mem.exists(w)) return ext_mem[w];
        return init_word(w);
    endfunction
    function automatic logic [15:0] ref_rd(input int unsigned w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction
    function automatic logic [23:0] cart_byte_addr(input logic [17:0] a);
        return CART_BASE + {6'd0, a[17:1], 1'b0};
    endfunction
    function automatic logic [23:0] bios_byte_addr(input logic [11:0] a);
        return BIOS_BASE + {12'd0, a[11:1], 1'b0};
    endfunction
    function automatic logic [7:0] exp_cart(input logic [17:0] a);
        logic [23:0] ba;
        logic [15:0] d;
        ba = cart_byte_addr(a);
        d  = ref_rd(32'(ba[23:1]));
        return a[0] ? d[15:8] : d[7:0];
    endfunction
    function automatic logic [7:0] exp_bios(input logic [11:0] a);
        logic [23:0] ba;
        logic [15:0] d;
        ba = bios_byte_addr(a);
        d  = ref_rd(32'(ba[23:1]));
        return a[0] ? d[15:8] : d[7:0];
    endfunction
    function automatic logic [23:0] dl_byte_addr(input logic [18:0] da);
        return da[18] ? bios_byte_addr(da[11:0]) : cart_byte_addr(da[17:0]);
    endfunction
    task automatic ref_write(input logic [18:0] da, input logic [7:0] dd);
        logic [23:0] ba;
        logic [15:0] d;
        ba = dl_byte_addr(da);
        d  = ref_rd(32'(ba[23:1]));
        if (da[0]) d[15:8] = dd; else d[7:0] = dd;
        ref_mem[32'(ba[23:1])] = d;
    endtask

    // ---------------- memory responder ----------------
    typedef struct packed {
        logic [23:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          seen_cyc;
    } req_t;
    req_t req_log[$];
    int   ack_log[$];
    bit   resp_en    = 1'b1;
    int   resp_delay = 1;      // negative: random 0..1 extra cycles
    bit   stray_ack  = 1'b0;
    int   cyc        = 0;

    initial begin : responder
        bit          in_flight;
        int          cnt;
        req_t        r;
        int unsigned w;
        logic [15:0] cur;
        in_flight = 1'b0;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge sysclk_7_143);
            cyc++;
            mem_ack = 1'b0;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (resp_en && mem_req === 1'b1) begin
                if (!in_flight) begin
                    in_flight  = 1'b1;
                    cnt        = (resp_delay < 0) ? int'($urandom_range(1, 0)) : resp_delay;
                    r.addr     = mem_addr;
                    r.we       = mem_we;
                    r.be       = mem_be;
                    r.wdata    = mem_wdata;
                    r.seen_cyc = cyc;
                    req_log.push_back(r);
                end
                if (cnt == 0) begin
                    w = 32'(mem_addr[23:1]);
                    if (mem_we) begin
                        cur = ext_rd(w);
                        if (mem_be[0]) cur[7:0]  = mem_wdata[7:0];
                        if (mem_be[1]) cur[15:8] = mem_wdata[15:8];
                        ext_mem[w] = cur;
                    end
                    mem_rdata = ext_rd(w);
                    mem_ack   = 1'b1;
                    ack_log.push_back(cyc);
                    in_flight = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                in_flight = 1'b0;
            end
        end
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge sysclk_7_143);
            #1;
        end
    endtask

    task automatic wait_dl_idle(input string tag);
        int k;
        k = 0;
        while (dl_wait !== 1'b0 && k < 20) begin
            cyc_wait(1);
            k++;
        end
        check(tag, 32'(dl_wait), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int          n0;
        bit          mc_valid;
        logic [16:0] mc_word;
        bit          mb_valid;
        logic [10:0] mb_word;
        ext_mem[2] = 16'hA55A;
        ref_mem[2] = 16'hA55A;

        // Reset state
        cyc_wait(3);
        check("rst_cart_out",  32'(cart_out),  32'hFF);
        check("rst_bios_out",  32'(bios_out),  32'hFF);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_be",    32'(mem_be),    32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_dl_wait",   32'(dl_wait),   32'd0);
        reset = 1'b0;
        cyc_wait(2);

        // Cart miss, ack two cycles after the request rises
        resp_delay = 1;
        n0 = req_log.size();
        cart_sel  = 1'b1;
        cart_addr = 18'h00005;
        cyc_wait(1);
        check("rd1_req",     32'(mem_req),  32'd1);
        check("rd1_addr",    32'(mem_addr), 32'h000004);
        check("rd1_we",      32'(mem_we),   32'd0);
        cyc_wait(1);
        check("rd1_hold_ff", 32'(cart_out), 32'hFF);
        cyc_wait(1);
        check("rd1_data_hi", 32'(cart_out), 32'hA5);
        cart_addr = 18'h00004;
        cyc_wait(2);
        check("rd1_data_lo", 32'(cart_out), 32'h5A);
        cyc_wait(2);
        check("rd1_nreq",    32'(req_log.size() - n0), 32'd1);
        cart_sel = 1'b0;

        // Download write while loading, second strobe ignored
        loading = 1'b1;
        n0 = req_log.size();
        dl_wr   = 1'b1;
        dl_addr = 19'h40003;
        dl_data = 8'h3C;
        cyc_wait(1);
        check("wr_dl_wait_set", 32'(dl_wait), 32'd1);
        check("wr_no_req_yet",  32'(mem_req), 32'd0);
        dl_addr = 19'h40010;
        dl_data = 8'h77;
        cyc_wait(1);
        dl_wr = 1'b0;
        check("wr_req",   32'(mem_req),   32'd1);
        check("wr_we",    32'(mem_we),    32'd1);
        check("wr_addr",  32'(mem_addr),  32'h040002);
        check("wr_be",    32'(mem_be),    32'h2);
        check("wr_wdata", 32'(mem_wdata), 32'h3C3C);
        wait_dl_idle("wr_dl_wait_clear");
        ref_write(19'h40003, 8'h3C);
        cyc_wait(4);
        check("wr_nreq", 32'(req_log.size() - n0), 32'd1);
        loading = 1'b0;
        cyc_wait(1);
        bios_sel  = 1'b1;
        bios_addr = 12'h003;
        cyc_wait(5);
        check("wr_bios_readback", 32'(bios_out), 32'h3C);
        bios_sel = 1'b0;
        cyc_wait(1);

        // Simultaneous cart and BIOS miss
        resp_delay = -1;
        n0 = req_log.size();
        cart_sel  = 1'b1;
        cart_addr = 18'h00031;
        bios_sel  = 1'b1;
        bios_addr = 12'h011;
        cyc_wait(10);
        check("dual_nreq", 32'(req_log.size() - n0), 32'd2);
        if (req_log.size() - n0 == 2 && ack_log.size() >= n0 + 1) begin
            check("dual_first_cart",  32'(req_log[n0].addr),     32'h000030);
            check("dual_second_bios", 32'(req_log[n0 + 1].addr), 32'h040010);
            check("dual_gap", 32'(req_log[n0 + 1].seen_cyc - ack_log[n0]), 32'd2);
        end
        check("dual_cart_out", 32'(cart_out), 32'(exp_cart(18'h00031)));
        check("dual_bios_out", 32'(bios_out), 32'(exp_bios(12'h011)));
        cart_sel = 1'b0;
        bios_sel = 1'b0;
        cyc_wait(1);

        // Write to a buffered word invalidates the buffer
        cart_sel  = 1'b1;
        cart_addr = 18'h00020;
        cyc_wait(5);
        check("inv_first_read", 32'(cart_out), 32'(exp_cart(18'h00020)));
        cart_sel = 1'b0;
        n0 = req_log.size();
        dl_wr   = 1'b1;
        dl_addr = 19'h00021;
        dl_data = 8'h99;
        cyc_wait(1);
        dl_wr = 1'b0;
        wait_dl_idle("inv_dl_wait_clear");
        ref_write(19'h00021, 8'h99);
        cart_sel  = 1'b1;
        cart_addr = 18'h00020;
        cyc_wait(5);
        check("inv_refetch_nreq", 32'(req_log.size() - n0), 32'd2);
        check("inv_reread_lo",    32'(cart_out), 32'(exp_cart(18'h00020)));
        cart_addr = 18'h00021;
        cyc_wait(2);
        check("inv_reread_hi",    32'(cart_out), 32'h99);
        check("inv_hi_nreq",      32'(req_log.size() - n0), 32'd2);
        cart_sel = 1'b0;
        cyc_wait(1);

        // Reset in the middle of a fetch, then a stray ack
        resp_en   = 1'b0;
        cart_sel  = 1'b1;
        cart_addr = 18'h00300;
        cyc_wait(1);
        check("mid_req_up", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req",      32'(mem_req),  32'd0);
        check("mid_rst_cart_out", 32'(cart_out), 32'hFF);
        check("mid_rst_addr",     32'(mem_addr), 32'd0);
        cart_sel = 1'b0;
        cyc_wait(2);
        reset = 1'b0;
        n0 = req_log.size();
        stray_ack = 1'b1;
        cyc_wait(1);
        stray_ack = 1'b0;
        cyc_wait(2);
        check("stray_req",      32'(mem_req),  32'd0);
        check("stray_cart_out", 32'(cart_out), 32'hFF);
        check("stray_bios_out", 32'(bios_out), 32'hFF);
        check("stray_dl_wait",  32'(dl_wait),  32'd0);
        resp_en = 1'b1;

        // Randomized reads and writes; buffers are empty after the reset
        mc_valid = 1'b0;
        mc_word  = '0;
        mb_valid = 1'b0;
        mb_word  = '0;
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [17:0] ca;
            logic [11:0] ba;
            logic [18:0] da;
            logic [7:0]  dd;
            bit          exp_req;
            kind = int'($urandom_range(9, 0));
            n0   = req_log.size();
            if (kind <= 3) begin
                ca = 18'($urandom_range(63, 0));
                exp_req = !(mc_valid && mc_word == ca[17:1]);
                cart_sel  = 1'b1;
                cart_addr = ca;
                cyc_wait(5);
                check("rnd_cart_data", 32'(cart_out), 32'(exp_cart(ca)));
                check("rnd_cart_nreq", 32'(req_log.size() - n0), 32'(exp_req));
                if (exp_req && req_log.size() > n0) begin
                    check("rnd_cart_addr", 32'(req_log[req_log.size() - 1].addr), 32'(cart_byte_addr(ca)));
                    check("rnd_cart_we",   32'(req_log[req_log.size() - 1].we),   32'd0);
                end
                mc_valid = 1'b1;
                mc_word  = ca[17:1];
                cart_sel = 1'b0;
                $display("txn %0d cart_read addr=%05h data=%02h", i, ca, cart_out);
            end else if (kind <= 7) begin
                ba = 12'($urandom_range(63, 0));
                exp_req = !(mb_valid && mb_word == ba[11:1]);
                bios_sel  = 1'b1;
                bios_addr = ba;
                cyc_wait(5);
                check("rnd_bios_data", 32'(bios_out), 32'(exp_bios(ba)));
                check("rnd_bios_nreq", 32'(req_log.size() - n0), 32'(exp_req));
                if (exp_req && req_log.size() > n0) begin
                    check("rnd_bios_addr", 32'(req_log[req_log.size() - 1].addr), 32'(bios_byte_addr(ba)));
                end
                mb_valid = 1'b1;
                mb_word  = ba[11:1];
                bios_sel = 1'b0;
                $display("txn %0d bios_read addr=%03h data=%02h", i, ba, bios_out);
            end else begin
                da = $urandom_range(1, 0) != 0 ? {1'b1, 12'd0, 6'($urandom_range(63, 0))}
                                               : {1'b0, 12'd0, 6'($urandom_range(63, 0))};
                dd = 8'($urandom_range(255, 0));
                dl_wr   = 1'b1;
                dl_addr = da;
                dl_data = dd;
                cyc_wait(1);
                dl_wr = 1'b0;
                wait_dl_idle("rnd_wr_dl_wait");
                check("rnd_wr_nreq", 32'(req_log.size() - n0), 32'd1);
                if (req_log.size() > n0) begin
                    check("rnd_wr_addr",  32'(req_log[req_log.size() - 1].addr),  32'(dl_byte_addr(da)));
                    check("rnd_wr_be",    32'(req_log[req_log.size() - 1].be),    da[0] ? 32'h2 : 32'h1);
                    check("rnd_wr_wdata", 32'(req_log[req_log.size() - 1].wdata), 32'({dd, dd}));
                end
                ref_write(da, dd);
                if (!da[18] && da[17:1] == mc_word) mc_valid = 1'b0;
                if ( da[18] && da[11:1] == mb_word) mb_valid = 1'b0;
                $display("txn %0d dl_write addr=%05h data=%02h", i, da, dd);
            end
            cyc_wait(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cart_rom_server.md
Name: cart_rom_server

Overview:
- Memory-side responder for the console's cartridge and BIOS fetch interface.
- Takes the byte-address/select pairs issued by the console top (cart_sel with cart_addr; bios_sel with bios_addr) and returns cart_out/bios_out bytes.
- Fetches 16-bit words from external SDRAM-style storage through a req/ack handshake and holds one word buffer per source.
- During ROM download it also accepts the loader's byte writes into the same storage.

Parameters:
- CART_BASE, 24'h000000, word-aligned byte base of cart image in external memory.
- BIOS_BASE, 24'h040000, word-aligned byte base of BIOS image in external memory.

Ports:
- sysclk_7_143  in   1   system clock; every register in this block uses it.
- reset         in   1   asynchronous, active-high reset.
- cart_sel      in   1   cart read select from console.
- cart_addr     in   18  cart byte address.
- cart_out      out  8   cart read data.
- bios_sel      in   1   BIOS read select.
- bios_addr     in   12  BIOS byte address.
- bios_out      out  8   BIOS read data.
- loading       in   1   ROM download in progress.
- dl_wr         in   1   one-cycle download write strobe.
- dl_addr       in   19  download byte address; bit18=0 cart, bit18=1 BIOS (bits 11:0 used).
- dl_data       in   8   download byte.
- dl_wait       out  1   download write pending; loader must not strobe.
- mem_req       out  1   external memory request.
- mem_we        out  1   request is a write.
- mem_addr      out  24  byte address; bit0 always 0.
- mem_be        out  2   byte enables; [0]=low byte (even address), [1]=high byte.
- mem_wdata     out  16  write data; the byte is replicated in both halves.
- mem_ack       in   1   one-cycle completion pulse.
- mem_rdata     in   16  read data, valid in the mem_ack cycle.

Behaviour:
- Reset values:
  - cart_out=8'hFF, bios_out=8'hFF.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, dl_wait=0.
  - Both buffers invalid, FSM in IDLE.
- Buffers: each holds valid, tag (word address), and data[15:0].
  - Hit when valid and tag equals addr[hi:1].
  - cart_out/bios_out are combinational: on a hit, the byte selected by addr[0] (0→data[7:0], 1→data[15:8]).
  - On a miss, the output keeps the last registered value (8'hFF after reset).
- FSM states: IDLE, RD_CART, RD_BIOS, WRITE, and PREF (PREF only with the optional feature).
- In IDLE, the request decision is made each cycle, in priority order:
  - pending download write → WRITE;
  - cart_sel and cart miss → RD_CART;
  - bios_sel and bios miss → RD_BIOS;
  - else stay in IDLE.
  - On the transition edge: mem_req=1, and mem_addr/mem_we/mem_be/mem_wdata are loaded.
- In RD_CART, RD_BIOS, WRITE and PREF:
  - mem_req and all mem_* outputs are held stable until mem_ack is sampled high.
  - On the ack edge: mem_req=0, return to IDLE, and the buffer is filled with tag set and valid=1 (read states).
  - mem_req is low for at least one cycle between requests.
- Address arithmetic:
  - cart read: mem_addr = CART_BASE + {cart_addr[17:1],1'b0}.
  - BIOS read: mem_addr = BIOS_BASE + {bios_addr[11:1],1'b0}.
  - Additions are 24-bit and wrap modulo 2^24.
- Read latency: a miss in cycle N gives mem_req high after edge N+1. With ack in cycle A, the output is valid after edge A. The system requires A ≤ N+3 to meet CPU/DMA bus timing.
- Select and address changes mid-fetch: the in-flight fetch completes and fills the buffer with its original tag. The new address is re-evaluated in IDLE.
- Download writes:
  - dl_wr with dl_wait=0 captures addr/data into the pending register and sets dl_wait=1 on the next edge.
  - dl_wr while dl_wait=1 is ignored.
  - dl_wait clears on the edge where the WRITE ack is sampled.
  - mem_be = dl_addr[0] ? 2'b10 : 2'b01.
  - A write whose word matches a buffer's tag invalidates that buffer on the ack edge.
- loading:
  - While loading=1, read misses are not issued; writes still are.
  - Both buffers are invalidated on every cycle where loading=1, and also on the falling edge of loading.
- Simultaneous cart and BIOS miss: the cart is served first, then the BIOS on the next IDLE cycle.
- Reset mid-transaction: everything returns to reset values immediately. A late mem_ack arriving in IDLE is ignored.

Optional Feature:
- Macro: CART_PREFETCH_EN.
- When defined:
  - After an RD_CART fill of word W, if there is no pending write and no BIOS miss, the FSM enters PREF and reads word W+1 (mem_addr+2, wrapping within 18-bit cart space).
  - PREF fills a second cart buffer (next-line). A cart read hitting the next-line buffer returns its data with no request issued.
  - The next-line buffer follows the same invalidation rules as the cart buffer.
  - A new cart miss arriving during PREF waits for the PREF ack.
- When undefined: there is no PREF state and no second buffer, and reads of W+1 miss normally.

Test Plan:
- Reset, then cart_sel=1, cart_addr=18'h00005; memory acks 2 cycles later with 16'hA55A → mem_addr=24'h000004, cart_out=8'hA5 after ack; cart_addr=18'h00004 then gives 8'h5A with no new mem_req.
- Loading=1, dl_wr with dl_addr=19'h40003, dl_data=8'h3C → dl_wait=1, mem_we=1, mem_addr=24'h040002, mem_be=2'b10, mem_wdata=16'h3C3C; dl_wait=0 after ack; a second dl_wr while waiting produces no extra request.
- cart_sel and bios_sel both miss in the same cycle → cart request issued first; BIOS request issued only after cart ack plus one idle cycle.
- Buffer holds tag for cart word 0x10, then download write to dl_addr=19'h00021 → buffer invalidated; next read of 18'h00020 issues a new mem_req.
- Reset asserted while mem_req=1 → mem_req=0 immediately; cart_out=8'hFF; a stray mem_ack afterwards changes nothing.
- With CART_PREFETCH_EN: read 18'h00100, then 18'h00102 → second mem_req at 24'h000102 issued automatically; the 18'h00102 read hits with no further request.
